// File: rtl/crc16_stream_engine_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the bit-serial CRC-16 stream engine: FSM state
// encoding and the common CRC-16 polynomial / init constants.
// No ports (package).
// -----------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        EMIT_HI = 2'd2,
        EMIT_LO = 2'd3
    } crc_state_e;

    localparam logic [15:0] CRC16_CCITT_POLY  = 16'h1021;
    localparam logic [15:0] CRC16_FALSE_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_XMODEM_INIT = 16'h0000;

endpackage

// File: rtl/crc16_stream_engine_if.sv
// -----------------------------------------------------------------------------
// crc16_stream_engine_if
// Groups the byte input handshake and the CRC byte output handshake.
//   in_valid/in_data/in_last/in_ready  : byte stream into the engine
//   out_valid/out_data/out_ready       : CRC bytes out of the engine
// Modports:
//   master : the surrounding logic (drives input bytes, consumes CRC bytes)
//   slave  : the engine itself
// -----------------------------------------------------------------------------
interface crc16_stream_engine_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/crc16_bit_step.sv
// -----------------------------------------------------------------------------
// crc16_bit_step
// Purely combinational single-bit CRC-16 update, MSB first, normal form.
// Ports:
//   crc_in  [15:0] : current CRC register
//   bit_in         : message bit being folded in
//   crc_out [15:0] : updated CRC register
// Parameter POLY selects the generator polynomial.
// -----------------------------------------------------------------------------
module crc16_bit_step
    import crc_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_CCITT_POLY
) (
    input  logic [15:0] crc_in,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic fb;

    assign fb      = bit_in ^ crc_in[15];
    assign crc_out = {crc_in[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

endmodule

// File: rtl/crc16_stream_engine.sv
// -----------------------------------------------------------------------------
// crc16_stream_engine
// Bit-serial CRC-16 engine. Accepts one byte at a time, folds it into the
// running CRC one bit per clock (8 clocks per byte), and after a byte marked
// last presents the CRC high byte then low byte on the output handshake.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   clear  : synchronous frame abort, reloads INIT
//   io     : byte in / CRC out handshakes (slave side)
//   busy   : high whenever the FSM is not in IDLE
//   crc_q  : live CRC register
// -----------------------------------------------------------------------------
module crc16_stream_engine
    import crc_pkg::*;
#(
    parameter logic [15:0] POLY   = CRC16_CCITT_POLY,
    parameter logic [15:0] INIT   = CRC16_FALSE_INIT,
    parameter logic [15:0] XOROUT = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    crc16_stream_engine_if.slave         io,
    output logic                         busy,
    output logic [15:0]                  crc_q
);

    crc_state_e  state_q, state_d;
    logic [15:0] crc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        last_q, last_d;
    logic [15:0] step_crc;

    logic        in_ready_c;
    logic        out_valid_c;
    logic [7:0]  out_data_c;

    crc16_bit_step #(.POLY(POLY)) u_step (
        .crc_in  (crc_q),
        .bit_in  (sh_q[7]),
        .crc_out (step_crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= 3'd0;
            sh_q    <= 8'h00;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        last_d      = last_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = 8'h00;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (io.in_valid) begin
                    sh_d    = io.in_data;
                    last_d  = io.in_last;
                    cnt_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                crc_d = step_crc;
                sh_d  = {sh_q[6:0], 1'b0};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    // Final bit of the byte; counter parks at 0 rather than wrapping.
                    cnt_d   = 3'd0;
                    last_d  = 1'b0;
                    state_d = last_q ? EMIT_HI : IDLE;
                end
            end
            EMIT_HI: begin
                out_valid_c = 1'b1;
                out_data_c  = crc_q[15:8] ^ XOROUT[15:8];
                if (io.out_ready) begin
                    state_d = EMIT_LO;
                end
            end
            EMIT_LO: begin
                out_valid_c = 1'b1;
                out_data_c  = crc_q[7:0] ^ XOROUT[7:0];
                if (io.out_ready) begin
                    crc_d   = INIT;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything above, including a byte offered in IDLE.
        if (clear) begin
            state_d = IDLE;
            crc_d   = INIT;
            cnt_d   = 3'd0;
            sh_d    = 8'h00;
            last_d  = 1'b0;
        end
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = out_valid_c;
    assign io.out_data  = out_data_c;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/crc16_stream_engine.md
Name: crc16_stream_engine

Overview:
- Bit-serial CRC-16 engine that sits directly upstream of the tile top-level output mux.
- Consumes a byte stream over a valid/ready handshake (sourced from ui_in) and folds each byte into a running CRC, MSB first, one bit per clock.
- On a byte flagged last, presents the finished CRC as two bytes, high byte first, on an output valid/ready handshake that the top level drives onto uo_out.
- Sized for a 1x1 TinyTapeout tile: no LUT, a single 16-bit LFSR.

Parameters:
- POLY, 16'h1021, generator polynomial in normal (non-reflected) form.
- INIT, 16'hFFFF, CRC register value after reset, clear, or completed frame.
- XOROUT, 16'h0000, XOR applied to the CRC bytes presented on out_data; the internal register is never XORed.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; the top derives it as the inverse of rst_n.
- clear  input  1  synchronous abort; discards the frame and reloads INIT.
- in_valid  input  1  in_data/in_last valid.
- in_data  input  8  byte to fold into the CRC.
- in_last  input  1  marks the final byte of a frame.
- in_ready  output  1  engine accepts a byte this cycle.
- out_valid  output  1  out_data holds a CRC byte.
- out_data  output  8  CRC byte (value XOR XOROUT slice).
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high in every state except IDLE.
- crc_q  output  16  live CRC register, for debug and bench visibility.

Behaviour:
- States: IDLE, SHIFT, EMIT_HI, EMIT_LO.
- Reset values: state=IDLE, crc=INIT, bit counter=0, shift byte=0, last flag=0, out_valid=0, out_data=0, in_ready=1, busy=0.
- IDLE: in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready: latch in_data into the shift byte, latch in_last, counter=7, go to SHIFT.
- SHIFT: in_ready=0. Each cycle:
  - b = shift_byte[7] ^ crc[15].
  - crc <= {crc[14:0],1'b0} ^ (b ? POLY : 0).
  - shift_byte <= shift_byte << 1; counter decrements.
  - When the update with counter==0 completes, go to EMIT_HI if last flag is set, otherwise IDLE.
- Timing: exactly 8 SHIFT cycles per byte. A byte accepted at edge E0 updates crc on edges E1..E8. in_ready is high again in the cycle after E8, so sustained throughput is 1 byte per 9 cycles.
- EMIT_HI: out_valid=1, out_data=crc[15:8]^XOROUT[15:8]. On out_ready, go to EMIT_LO.
- EMIT_LO: out_valid=1, out_data=crc[7:0]^XOROUT[7:0]. On out_ready, crc<=INIT and go to IDLE.
- Output stability: while out_valid & !out_ready, out_data and crc_q must hold stable. out_ready while out_valid=0 is ignored.
- in_valid during SHIFT/EMIT_HI/EMIT_LO is not accepted (in_ready=0). The upstream must hold the byte.
- clear: in any state, on the next edge, go to IDLE with crc=INIT, counter=0, last flag=0. Any pending output is dropped.
- Priority: reset > clear > normal operation.
- clear and in_valid asserted together in IDLE: clear wins and the byte is not accepted. in_ready is still 1 that cycle, so the upstream must treat clear as a frame abort.
- in_ready and out_valid are never both high.
- A frame continues until in_last. There is no length limit and no internal counter overflow.
- Reset asserted mid-SHIFT or mid-EMIT: all state returns to reset values on that edge.

Decomposition:
- Shared package crc_pkg holds:
  - state enum (IDLE, SHIFT, EMIT_HI, EMIT_LO);
  - CRC16_CCITT_POLY=16'h1021, CRC16_FALSE_INIT=16'hFFFF, CRC16_XMODEM_INIT=16'h0000.
- Sub-module crc16_bit_step: purely combinational one-bit update with inputs crc_in[15:0], bit_in, POLY and output crc_out[15:0]. It is reused by the bench's reference model.

Test Plan:
- Reset, then single byte 0x41 with in_last=1, default params -> crc_q=16'hB915 after 8 SHIFT cycles; out_data 0xB9 then 0x15; busy low after the second out_ready.
- ASCII "123456789" (0x31..0x39), last on 0x39, in_valid held high -> in_ready pulses exactly once per 9 cycles; output bytes 0x29, 0xB1.
- INIT=16'h0000, same "123456789" frame -> output 0x31, 0xC3 (XMODEM); second frame right after gives the same result, confirming INIT reload.
- Backpressure: out_ready low for 5 cycles in EMIT_HI -> out_valid stays 1 and out_data stays 0x29; no in_ready during the stall.
- clear asserted in SHIFT cycle 4 of byte 0x31 -> next cycle state=IDLE, crc_q=16'hFFFF, in_ready=1; then "A" with last -> 0xB915.
- reset asserted during EMIT_LO -> next cycle out_valid=0, out_data=0, crc_q=16'hFFFF, in_ready=1, busy=0.
